// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, global memory stall and a saturating bubble counter.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             IDValid_i,
   input  logic [4:0]       IDRs1_i,
   input  logic [4:0]       IDRs2_i,
   input  logic [4:0]       IDRd_i,
   input  logic             IDRegWrite_i,
   input  logic             IDMemRead_i,
   input  logic             IDMemWrite_i,
   input  logic             IDMemToReg_i,
   input  logic             IDALUSrc_i,
   input  logic [1:0]       IDALUOp_i,
   input  logic [9:0]       IDFunct_i,
   input  logic [XLEN-1:0]  IDRs1Data_i,
   input  logic [XLEN-1:0]  IDRs2Data_i,
   input  logic [XLEN-1:0]  IDImm_i,
   input  logic             Flush_i,
   input  logic             MemStall_i,
   output logic             EXValid_o,
   output logic [4:0]       EXRs1_o,
   output logic [4:0]       EXRs2_o,
   output logic [4:0]       EXRd_o,
   output logic             EXRegWrite_o,
   output logic             EXMemRead_o,
   output logic             EXMemWrite_o,
   output logic             EXMemToReg_o,
   output logic             EXALUSrc_o,
   output logic [1:0]       EXALUOp_o,
   output logic [9:0]       EXFunct_o,
   output logic [XLEN-1:0]  EXRs1Data_o,
   output logic [XLEN-1:0]  EXRs2Data_o,
   output logic [XLEN-1:0]  EXImm_o,
   output logic             Stall_o,
   output logic [CNT_W-1:0] LoadUseCnt_o
);

   typedef struct packed {
      logic            valid;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            alu_src;
      logic [1:0]      alu_op;
      logic [9:0]      funct;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
   } ex_pkt_t;

   ex_pkt_t          ex_q, ex_d, id_pkt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lu;

   assign id_pkt = '{valid:      IDValid_i,
                     rs1:        IDRs1_i,
                     rs2:        IDRs2_i,
                     rd:         IDRd_i,
                     reg_write:  IDRegWrite_i,
                     mem_read:   IDMemRead_i,
                     mem_write:  IDMemWrite_i,
                     mem_to_reg: IDMemToReg_i,
                     alu_src:    IDALUSrc_i,
                     alu_op:     IDALUOp_i,
                     funct:      IDFunct_i,
                     rs1_data:   IDRs1Data_i,
                     rs2_data:   IDRs2Data_i,
                     imm:        IDImm_i};

   // Both sources are compared even if the instruction does not read rs2.
   assign lu = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & IDValid_i &
               ((ex_q.rd == IDRs1_i) | (ex_q.rd == IDRs2_i));

   assign Stall_o = lu & ~Flush_i;

   always_comb begin
      // NOTE: defaults first so every path assigns ex_d/cnt_d and no latch is inferred.
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (!MemStall_i) begin
         if (Flush_i) begin
            ex_d = '0;
         end else if (lu) begin
            ex_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
         end else begin
            ex_d = id_pkt;
         end
      end
   end

   // An all-zero packet is the bubble: rd=0 keeps the forwarding unit from matching it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: non-blocking assignments for all state so registers update together.
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign EXValid_o    = ex_q.valid;
   assign EXRs1_o      = ex_q.rs1;
   assign EXRs2_o      = ex_q.rs2;
   assign EXRd_o       = ex_q.rd;
   assign EXRegWrite_o = ex_q.reg_write;
   assign EXMemRead_o  = ex_q.mem_read;
   assign EXMemWrite_o = ex_q.mem_write;
   assign EXMemToReg_o = ex_q.mem_to_reg;
   assign EXALUSrc_o   = ex_q.alu_src;
   assign EXALUOp_o    = ex_q.alu_op;
   assign EXFunct_o    = ex_q.funct;
   assign EXRs1Data_o  = ex_q.rs1_data;
   assign EXRs2Data_o  = ex_q.rs2_data;
   assign EXImm_o      = ex_q.imm;
   assign LoadUseCnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation scenario.
module tb_id_ex_stage;

   logic        clk, rst_n;
   logic        id_valid, id_rw, id_mr, id_mw, id_m2r, id_asrc, flush, mem_stall;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [1:0]  id_aop;
   logic [9:0]  id_fn;
   logic [31:0] id_d1, id_d2, id_imm;

   logic        EXValid_o, EXRegWrite_o, EXMemRead_o, EXMemWrite_o, EXMemToReg_o, EXALUSrc_o;
   logic [4:0]  EXRs1_o, EXRs2_o, EXRd_o;
   logic [1:0]  EXALUOp_o;
   logic [9:0]  EXFunct_o;
   logic [31:0] EXRs1Data_o, EXRs2Data_o, EXImm_o;
   logic        Stall_o;
   logic [15:0] LoadUseCnt_o;

   logic        s_valid, s_rw, s_mr, s_mw, s_m2r, s_asrc, s_stall;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   logic [1:0]  s_aop;
   logic [9:0]  s_fn;
   logic [31:0] s_d1, s_d2, s_imm;
   logic [1:0]  s_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .IDValid_i(id_valid), .IDRs1_i(id_rs1), .IDRs2_i(id_rs2), .IDRd_i(id_rd),
      .IDRegWrite_i(id_rw), .IDMemRead_i(id_mr), .IDMemWrite_i(id_mw),
      .IDMemToReg_i(id_m2r), .IDALUSrc_i(id_asrc), .IDALUOp_i(id_aop),
      .IDFunct_i(id_fn), .IDRs1Data_i(id_d1), .IDRs2Data_i(id_d2), .IDImm_i(id_imm),
      .Flush_i(flush), .MemStall_i(mem_stall),
      .EXValid_o(EXValid_o), .EXRs1_o(EXRs1_o), .EXRs2_o(EXRs2_o), .EXRd_o(EXRd_o),
      .EXRegWrite_o(EXRegWrite_o), .EXMemRead_o(EXMemRead_o), .EXMemWrite_o(EXMemWrite_o),
      .EXMemToReg_o(EXMemToReg_o), .EXALUSrc_o(EXALUSrc_o), .EXALUOp_o(EXALUOp_o),
      .EXFunct_o(EXFunct_o), .EXRs1Data_o(EXRs1Data_o), .EXRs2Data_o(EXRs2Data_o),
      .EXImm_o(EXImm_o), .Stall_o(Stall_o), .LoadUseCnt_o(LoadUseCnt_o)
   );

   id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
      .clk_i(clk), .rst_n_i(rst_n),
      .IDValid_i(id_valid), .IDRs1_i(id_rs1), .IDRs2_i(id_rs2), .IDRd_i(id_rd),
      .IDRegWrite_i(id_rw), .IDMemRead_i(id_mr), .IDMemWrite_i(id_mw),
      .IDMemToReg_i(id_m2r), .IDALUSrc_i(id_asrc), .IDALUOp_i(id_aop),
      .IDFunct_i(id_fn), .IDRs1Data_i(id_d1), .IDRs2Data_i(id_d2), .IDImm_i(id_imm),
      .Flush_i(flush), .MemStall_i(mem_stall),
      .EXValid_o(s_valid), .EXRs1_o(s_rs1), .EXRs2_o(s_rs2), .EXRd_o(s_rd),
      .EXRegWrite_o(s_rw), .EXMemRead_o(s_mr), .EXMemWrite_o(s_mw),
      .EXMemToReg_o(s_m2r), .EXALUSrc_o(s_asrc), .EXALUOp_o(s_aop),
      .EXFunct_o(s_fn), .EXRs1Data_o(s_d1), .EXRs2Data_o(s_d2),
      .EXImm_o(s_imm), .Stall_o(s_stall), .LoadUseCnt_o(s_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic m2r, input logic asrc,
                         input logic [1:0] aop, input logic [9:0] fn,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm);
      id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rw = rw;    id_mr = mr;   id_mw = mw;   id_m2r = m2r; id_asrc = asrc;
      id_aop = aop;  id_fn = fn;   id_d1 = d1;   id_d2 = d2;   id_imm = imm;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 10'd0, 32'd0, 32'd0, 32'd0);
      flush = 0;
      mem_stall = 0;
   endtask

   // lw rd, imm(rs1)
   task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
      set_id(1, rs1, 5'd0, rd, 1, 1, 0, 1, 1, 2'd0, 10'd2, 32'h100, 32'd0, 32'd4);
   endtask

   // add rd, rs1, rs2
   task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      set_id(1, rs1, rs2, rd, 1, 0, 0, 0, 0, 2'd2, 10'd0, 32'd10, 32'd20, 32'd0);
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle();
      #3;
      checks++; if (EXValid_o !== 1'b0) begin errors++; $display("FAIL reset_init_valid: got %b want 0", EXValid_o); end
      checks++; if (LoadUseCnt_o !== 16'd0) begin errors++; $display("FAIL reset_init_cnt: got %0d want 0", LoadUseCnt_o); end
      @(negedge clk) rst_n = 1;
      step();
      set_id(1, 5'd1, 5'd2, 5'd7, 1, 0, 1, 0, 1, 2'd1, 10'h3FF, 32'hDEAD_BEEF, 32'h1, 32'hFFFF_FFF0);
      step();
      checks++; if (EXRd_o !== 5'd7) begin errors++; $display("FAIL reset_preload_rd: got %0d want 7", EXRd_o); end
      #2 rst_n = 0;
      #1;
      checks++; if (EXValid_o !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %b want 0", EXValid_o); end
      checks++; if (EXRd_o !== 5'd0) begin errors++; $display("FAIL reset_async_rd: got %0d want 0", EXRd_o); end
      checks++; if (EXRs1Data_o !== 32'd0) begin errors++; $display("FAIL reset_async_d1: got %h want 0", EXRs1Data_o); end
      checks++; if (EXImm_o !== 32'd0 || EXFunct_o !== 10'd0 || EXMemWrite_o !== 1'b0) begin
         errors++; $display("FAIL reset_async_misc: imm=%h funct=%h mw=%b want 0", EXImm_o, EXFunct_o, EXMemWrite_o); end
      exp_cnt = 0;
      @(negedge clk) rst_n = 1;
      idle();
      step();
   endtask

   task automatic test_pass_through();
      set_add(5'd3, 5'd1, 5'd2);
      id_imm = 32'hFFFF_FFF0;
      #1;
      checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b want 0", Stall_o); end
      step();
      checks++; if (EXRd_o !== 5'd3 || EXRs1_o !== 5'd1 || EXRs2_o !== 5'd2) begin
         errors++; $display("FAIL pass_regs: rd=%0d rs1=%0d rs2=%0d want 3 1 2", EXRd_o, EXRs1_o, EXRs2_o); end
      checks++; if (EXRegWrite_o !== 1'b1 || EXValid_o !== 1'b1 || EXALUOp_o !== 2'd2) begin
         errors++; $display("FAIL pass_ctrl: rw=%b v=%b aop=%0d want 1 1 2", EXRegWrite_o, EXValid_o, EXALUOp_o); end
      checks++; if (EXRs1Data_o !== 32'd10 || EXRs2Data_o !== 32'd20 || EXImm_o !== 32'hFFFF_FFF0) begin
         errors++; $display("FAIL pass_data: d1=%h d2=%h imm=%h want a 14 fffffff0", EXRs1Data_o, EXRs2Data_o, EXImm_o); end
      idle();
      step();
   endtask

   task automatic test_load_use();
      set_lw(5'd5, 5'd1);
      step();
      set_add(5'd6, 5'd7, 5'd5);
      #1;
      checks++; if (Stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", Stall_o); end
      step();
      exp_cnt++;
      checks++; if (EXValid_o !== 1'b0 || EXRegWrite_o !== 1'b0 || EXRd_o !== 5'd0 || EXRs2_o !== 5'd0 || EXMemRead_o !== 1'b0) begin
         errors++; $display("FAIL lu_bubble: v=%b rw=%b rd=%0d rs2=%0d mr=%b want all 0", EXValid_o, EXRegWrite_o, EXRd_o, EXRs2_o, EXMemRead_o); end
      checks++; if (LoadUseCnt_o !== exp_cnt[15:0]) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", LoadUseCnt_o, exp_cnt); end
      checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_after: got %b want 0", Stall_o); end
      step();
      checks++; if (EXRd_o !== 5'd6 || EXRs2_o !== 5'd5 || EXValid_o !== 1'b1) begin
         errors++; $display("FAIL lu_reload: rd=%0d rs2=%0d v=%b want 6 5 1", EXRd_o, EXRs2_o, EXValid_o); end
      idle();
      step();
   endtask

   task automatic test_back_to_back();
      set_lw(5'd5, 5'd1);
      step();
      set_lw(5'd6, 5'd5);                // dependent via rs1, itself a load
      #1;
      checks++; if (Stall_o !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b want 1", Stall_o); end
      step();
      exp_cnt++;
      step();
      checks++; if (EXRd_o !== 5'd6 || EXMemRead_o !== 1'b1) begin
         errors++; $display("FAIL b2b_load2: rd=%0d mr=%b want 6 1", EXRd_o, EXMemRead_o); end
      set_add(5'd8, 5'd2, 5'd6);
      #1;
      checks++; if (Stall_o !== 1'b1) begin errors++; $display("FAIL b2b_stall2: got %b want 1", Stall_o); end
      step();
      exp_cnt++;
      checks++; if (LoadUseCnt_o !== exp_cnt[15:0] || EXRd_o !== 5'd0) begin
         errors++; $display("FAIL b2b_bubble2: cnt=%0d rd=%0d want %0d 0", LoadUseCnt_o, EXRd_o, exp_cnt); end
      step();
      checks++; if (EXRd_o !== 5'd8) begin errors++; $display("FAIL b2b_consumer: got %0d want 8", EXRd_o); end
      idle();
      step();
   endtask

   task automatic test_x0_flush();
      set_lw(5'd0, 5'd1);
      step();
      set_add(5'd4, 5'd0, 5'd3);
      #1;
      checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", Stall_o); end
      step();
      checks++; if (EXRd_o !== 5'd4 || LoadUseCnt_o !== exp_cnt[15:0]) begin
         errors++; $display("FAIL x0_load: rd=%0d cnt=%0d want 4 %0d", EXRd_o, LoadUseCnt_o, exp_cnt); end
      set_lw(5'd5, 5'd1);
      step();
      set_add(5'd6, 5'd5, 5'd2);
      flush = 1;
      #1;
      checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", Stall_o); end
      step();
      flush = 0;
      checks++; if (EXValid_o !== 1'b0 || EXRd_o !== 5'd0 || EXRs1_o !== 5'd0 || LoadUseCnt_o !== exp_cnt[15:0]) begin
         errors++; $display("FAIL flush_bubble: v=%b rd=%0d rs1=%0d cnt=%0d want 0 0 0 %0d", EXValid_o, EXRd_o, EXRs1_o, LoadUseCnt_o, exp_cnt); end
      idle();
      step();
   endtask

   task automatic test_mem_stall();
      set_id(1, 5'd1, 5'd2, 5'd9, 1, 1, 0, 1, 1, 2'd0, 10'd2, 32'h55, 32'h66, 32'h1234);
      step();
      mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, (i == 0) ? 5'd9 : 5'd1, 5'd2, 5'(10 + i), 1, 0, 1, 0, 0, 2'd3, 10'(i),
                32'(i), 32'hAAAA, 32'(100 + i));
         #1;
         checks++; if (Stall_o !== (i == 0)) begin errors++; $display("FAIL ms_stall_%0d: got %b want %b", i, Stall_o, (i == 0)); end
         step();
         checks++; if (EXRd_o !== 5'd9 || EXMemRead_o !== 1'b1 || EXImm_o !== 32'h1234 || EXRs1Data_o !== 32'h55 || LoadUseCnt_o !== exp_cnt[15:0]) begin
            errors++; $display("FAIL ms_hold_%0d: rd=%0d mr=%b imm=%h d1=%h cnt=%0d want 9 1 1234 55 %0d", i, EXRd_o, EXMemRead_o, EXImm_o, EXRs1Data_o, LoadUseCnt_o, exp_cnt); end
      end
      set_add(5'd20, 5'd1, 5'd2);
      mem_stall = 0;
      step();
      checks++; if (EXRd_o !== 5'd20 || EXValid_o !== 1'b1 || EXMemRead_o !== 1'b0) begin
         errors++; $display("FAIL ms_release: rd=%0d v=%b mr=%b want 20 1 0", EXRd_o, EXValid_o, EXMemRead_o); end
      idle();
      step();
   endtask

   task automatic test_saturation();
      #2 rst_n = 0;
      #1;
      exp_cnt = 0;
      checks++; if (s_cnt !== 2'd0) begin errors++; $display("FAIL sat_reset: got %0d want 0", s_cnt); end
      @(negedge clk) rst_n = 1;
      step();
      for (int i = 0; i < 5; i++) begin
         set_lw(5'd5, 5'd1);
         step();
         set_add(5'd6, 5'd3, 5'd5);
         step();
         exp_cnt++;
         checks++; if (s_cnt !== ((i < 2) ? 2'(i + 1) : 2'd3)) begin
            errors++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, s_cnt, (i < 2) ? i + 1 : 3); end
         checks++; if (LoadUseCnt_o !== exp_cnt[15:0]) begin
            errors++; $display("FAIL sat_wide_cnt_%0d: got %0d want %0d", i, LoadUseCnt_o, exp_cnt); end
      end
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_back_to_back();
      test_x0_flush();
      test_mem_stall();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
